// File: rtl/arb_defs.sv
`default_nettype none
// ============================================================================
// Package     : arb_defs
// Description : Shared state encodings, sizing constants and the rotating
//               priority scan used by the 8-way round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_defs;

  localparam int unsigned c_req_n = 8;
  localparam int unsigned c_idx_w = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // First set request bit scanning ptr, ptr+1, ... ptr+7 (mod 8). Scanning
  // from the far end lets the nearest hit overwrite earlier ones.
  function automatic logic [c_idx_w-1:0] rr_pick(
    input logic [c_req_n-1:0] req,
    input logic [c_idx_w-1:0] ptr
  );
    logic [c_idx_w-1:0] pick;
    logic [c_idx_w-1:0] idx;
    pick = ptr;
    for (int k = c_req_n - 1; k >= 0; k--) begin
      idx = ptr + c_idx_w'(k);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/decoder3to8.sv
`default_nettype none
// ============================================================================
// Module      : decoder3to8
// Description : 3-to-8 one-hot decoder with enable; all outputs low when
//               the enable is low.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder3to8 (
  input  logic [2:0] sel_i,
  input  logic       en_i,
  output logic [7:0] dec_o
);

  // One output bit per select code, gated by the enable
  for (genvar i = 0; i < 8; i++) begin : g_dec
    assign dec_o[i] = en_i && (sel_i == 3'(i));
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter8
// Description : 8-way round-robin arbiter. A winner keeps the grant until it
//               pulses done, drops its request, or holds for MAX_HOLD cycles;
//               one dead cycle follows every release, then priority rotates
//               to the requester after the previous holder.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8
  import arb_defs::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [c_req_n-1:0] req,
  input  logic               done,
  output logic [c_req_n-1:0] grant,
  output logic [c_idx_w-1:0] grant_idx,
  output logic               grant_valid,
  output logic               timeout
);

  // Counter value seen on the last allowed hold cycle; unused when disabled
  localparam logic [7:0] c_hold_last = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
  localparam logic       c_to_en     = (MAX_HOLD != 0);

  state_t               state_q;
  logic [c_idx_w-1:0]   ptr_q;
  logic [c_idx_w-1:0]   idx_q;
  logic                 valid_q;
  logic                 timeout_q;
  logic [7:0]           cnt_q;

  logic                 w_holder_req;
  logic                 w_expired;
  logic                 w_release;
  logic                 w_forced;
  logic [c_idx_w-1:0]   w_pick;

  // Release decode for the current holder and the next round-robin winner
  always_comb begin
    w_holder_req = req[idx_q];
    w_expired    = c_to_en && (cnt_q == c_hold_last);
    w_release    = done || !w_holder_req || w_expired;
    w_forced     = w_expired && !done && w_holder_req;
    w_pick       = rr_pick(req, ptr_q);
  end

  // Arbitration FSM with registered grant index, valid and timeout pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req != '0) begin
            idx_q   <= w_pick;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            valid_q   <= 1'b0;
            ptr_q     <= idx_q + 3'd1;
            timeout_q <= w_forced;
            state_q   <= ST_GAP;
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        ST_GAP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout     = timeout_q;

  decoder3to8 u_dec (
    .sel_i (idx_q),
    .en_i  (valid_q),
    .dec_o (grant)
  );

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter8
// Description : Self-checking bench for rr_arbiter8 with a behavioural
//               owner/dead-cycle model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  rr_arbiter8 #(.MAX_HOLD(HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: who owns the resource, how long it has shown, dead cycle flag
  int m_owner = -1;
  bit m_dead  = 1'b0;
  int m_ptr   = 0;
  int m_shown = 0;
  int m_last  = 0;
  bit m_to    = 1'b0;
  bit m_still;
  bit m_expired;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner = -1; m_dead = 1'b0; m_ptr = 0; m_shown = 0; m_last = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner >= 0) begin
        m_still   = req[m_owner];
        m_expired = (HOLD != 0) && (m_shown + 1 == HOLD);
        if (done || !m_still || m_expired) begin
          m_to    = m_expired && !done && m_still;
          m_ptr   = (m_owner + 1) % 8;
          m_owner = -1;
          m_dead  = 1'b1;
        end else begin
          m_shown++;
        end
      end else if (m_dead) begin
        m_dead = 1'b0;
      end else if (req != 8'h00) begin
        for (int k = 0; k < 8; k++)
          if (m_owner < 0 && req[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
        m_last  = m_owner;
        m_shown = 0;
      end
    end
  end

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle, away from the rising edge, compare DUT against the model
  bit   run_cmp = 1'b0;
  logic [7:0] m_grant;
  always @(negedge clk) begin
    if (run_cmp) begin
      m_grant = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
      check("model_grant", grant, m_grant);
      check("model_valid", {7'd0, grant_valid}, {7'd0, m_owner >= 0});
      check("model_timeout", {7'd0, timeout}, {7'd0, m_to});
      if (m_owner >= 0) check("model_idx", {5'd0, grant_idx}, 8'(m_last));
    end
  end

  // Drive one cycle of inputs and land on the following falling edge
  task automatic cyc(input logic [7:0] r, input logic d);
    req  = r;
    done = d;
    @(negedge clk);
  endtask

  task automatic lit(input string nm, input logic [7:0] g, input logic to);
    check({nm, "_grant"}, grant, g);
    check({nm, "_timeout"}, {7'd0, timeout}, {7'd0, to});
  endtask

  logic [7:0] rot_exp [9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

  initial begin
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    run_cmp = 1'b1;

    // Reset held with all requests asserted
    cyc(8'hFF, 1'b0);
    lit("rst1", 8'h00, 1'b0);
    check("rst1_valid", {7'd0, grant_valid}, 8'h00);
    check("rst1_idx", {5'd0, grant_idx}, 8'h00);
    cyc(8'hFF, 1'b0);
    lit("rst2", 8'h00, 1'b0);
    rst_n = 1'b1;
    cyc(8'hFF, 1'b0);

    // Rotation with done in each first grant cycle
    for (int i = 0; i < 9; i++) begin
      lit("rot", rot_exp[i], 1'b0);
      cyc(8'hFF, 1'b1);
      lit("rot_gap", 8'h00, 1'b0);
      cyc(8'hFF, 1'b0);
      lit("rot_idle", 8'h00, 1'b0);
      cyc(8'hFF, 1'b0);
    end
    lit("rot_last", 8'h02, 1'b0);
    cyc(8'hFF, 1'b1);
    cyc(8'h00, 1'b0);
    cyc(8'h00, 1'b0);

    // Single requester, release and regrant two cycles later
    cyc(8'h04, 1'b0);
    lit("single", 8'h04, 1'b0);
    check("single_idx", {5'd0, grant_idx}, 8'h02);
    cyc(8'h04, 1'b1);
    lit("single_gap", 8'h00, 1'b0);
    cyc(8'h04, 1'b0);
    lit("single_idle", 8'h00, 1'b0);
    cyc(8'h04, 1'b0);
    lit("single_again", 8'h04, 1'b0);

    // Holder drops its request without done
    cyc(8'h00, 1'b0);
    lit("drop_gap", 8'h00, 1'b0);
    cyc(8'h40, 1'b0);
    cyc(8'h40, 1'b0);
    lit("wrap_g6", 8'h40, 1'b0);
    cyc(8'h81, 1'b1);
    cyc(8'h81, 1'b0);
    cyc(8'h81, 1'b0);
    lit("wrap_g7", 8'h80, 1'b0);
    cyc(8'h81, 1'b1);
    cyc(8'h81, 1'b0);
    cyc(8'h81, 1'b0);
    lit("wrap_g0", 8'h01, 1'b0);
    cyc(8'h00, 1'b0);
    cyc(8'h00, 1'b0);

    // Timeout: sole requester held for exactly HOLD cycles, then regranted
    cyc(8'h08, 1'b0);
    lit("to_c1", 8'h08, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h08, 1'b0);
      lit("to_hold", 8'h08, 1'b0);
    end
    cyc(8'h08, 1'b0);
    lit("to_gap", 8'h00, 1'b1);
    cyc(8'h08, 1'b0);
    lit("to_idle", 8'h00, 1'b0);
    cyc(8'h08, 1'b0);
    lit("to_regrant", 8'h08, 1'b0);
    // done coinciding with the timeout match is a normal release
    cyc(8'h08, 1'b0);
    cyc(8'h08, 1'b0);
    cyc(8'h08, 1'b0);
    cyc(8'h08, 1'b1);
    lit("to_with_done", 8'h00, 1'b0);
    cyc(8'h00, 1'b0);

    // Reset while requester 5 holds the grant
    cyc(8'h20, 1'b0);
    lit("mid_grant", 8'h20, 1'b0);
    rst_n = 1'b0;
    cyc(8'h21, 1'b0);
    lit("mid_rst", 8'h00, 1'b0);
    check("mid_rst_idx", {5'd0, grant_idx}, 8'h00);
    rst_n = 1'b1;
    cyc(8'h21, 1'b0);
    lit("post_rst", 8'h01, 1'b0);

    // Random traffic: mostly stable request sets, sparse done and reset
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: req = 8'h00;
          1: req = 8'(1 << $urandom_range(0, 7));
          2: req = 8'($urandom);
          default: req = 8'hFF;
        endcase
      end
      done = ($urandom_range(0, 4) == 0);
      @(negedge clk);
    end

    run_cmp = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
